// File: rtl/scr1_dmem_arb.sv
// Two-port data-memory arbiter: one outstanding transaction, response routed to the owner.
// Round-robin or fixed-priority grant selected by ARB_RR.
module scr1_dmem_arb #(
  parameter int DMEM_AWIDTH = 32,
  parameter int DMEM_DWIDTH = 32,
  parameter bit ARB_RR      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req_i,
  input  logic                   p0_cmd_i,
  input  logic [1:0]             p0_width_i,
  input  logic [DMEM_AWIDTH-1:0] p0_addr_i,
  input  logic [DMEM_DWIDTH-1:0] p0_wdata_i,
  output logic                   p0_req_ack_o,
  output logic [DMEM_DWIDTH-1:0] p0_rdata_o,
  output logic [1:0]             p0_resp_o,
  input  logic                   p1_req_i,
  input  logic                   p1_cmd_i,
  input  logic [1:0]             p1_width_i,
  input  logic [DMEM_AWIDTH-1:0] p1_addr_i,
  input  logic [DMEM_DWIDTH-1:0] p1_wdata_i,
  output logic                   p1_req_ack_o,
  output logic [DMEM_DWIDTH-1:0] p1_rdata_o,
  output logic [1:0]             p1_resp_o,
  output logic                   dmem_req_o,
  output logic                   dmem_cmd_o,
  output logic [1:0]             dmem_width_o,
  output logic [DMEM_AWIDTH-1:0] dmem_addr_o,
  output logic [DMEM_DWIDTH-1:0] dmem_wdata_o,
  input  logic                   dmem_req_ack_i,
  input  logic [DMEM_DWIDTH-1:0] dmem_rdata_i,
  input  logic [1:0]             dmem_resp_i,
  output logic                   arb_unexp_resp_o
);

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_RDY_OK = 2'd1;
  localparam logic [1:0] RESP_RDY_ER = 2'd2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  arb_state_t state_ff;
  arb_state_t state_next;
  logic       owner_ff;
  logic       rr_ptr_ff;

  logic       grant;
  logic       any_req;
  logic       idle;
  logic       accept;
  logic       resp_final;

  assign any_req    = p0_req_i | p1_req_i;
  assign idle       = (state_ff == ARB_IDLE);
  assign resp_final = (dmem_resp_i == RESP_RDY_OK) | (dmem_resp_i == RESP_RDY_ER);

  // Grant is forced to port 0 in reset so the muxed fields follow port 0 there.
  always_comb begin
    grant = 1'b0;
    if (rst_n) begin
      if (p0_req_i & p1_req_i) begin
        grant = ARB_RR ? rr_ptr_ff : 1'b0;
      end else if (p1_req_i) begin
        grant = 1'b1;
      end
    end
  end

  assign dmem_req_o   = rst_n & idle & any_req;
  assign accept       = dmem_req_o & dmem_req_ack_i;
  assign p0_req_ack_o = accept & ~grant;
  assign p1_req_ack_o = accept & grant;

  assign dmem_cmd_o   = grant ? p1_cmd_i   : p0_cmd_i;
  assign dmem_width_o = grant ? p1_width_i : p0_width_i;
  assign dmem_addr_o  = grant ? p1_addr_i  : p0_addr_i;
  assign dmem_wdata_o = grant ? p1_wdata_i : p0_wdata_i;

  always_comb begin
    state_next = state_ff;
    case (state_ff)
      ARB_IDLE: if (accept)     state_next = ARB_BUSY;
      ARB_BUSY: if (resp_final) state_next = ARB_IDLE;
      default:                  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_ff  <= ARB_IDLE;
      owner_ff  <= 1'b0;
      rr_ptr_ff <= 1'b0;
    end else begin
      state_ff <= state_next;
      if (accept) begin
        owner_ff <= grant;
        if (ARB_RR) rr_ptr_ff <= ~grant;
      end
    end
  end

  assign p0_rdata_o = dmem_rdata_i;
  assign p1_rdata_o = dmem_rdata_i;
  assign p0_resp_o  = (rst_n & ~idle & ~owner_ff) ? dmem_resp_i : RESP_NOTRDY;
  assign p1_resp_o  = (rst_n & ~idle &  owner_ff) ? dmem_resp_i : RESP_NOTRDY;

  assign arb_unexp_resp_o = rst_n & idle & resp_final;

`ifndef SYNTHESIS
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({p0_req_ack_o, p1_req_ack_o}));
  a_no_req_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_ff == ARB_BUSY) |-> !dmem_req_o);
  a_resp_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({p0_resp_o != RESP_NOTRDY, p1_resp_o != RESP_NOTRDY}));
  a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
    dmem_req_o |-> !$isunknown({dmem_cmd_o, dmem_width_o, dmem_addr_o, dmem_wdata_o}));
`endif

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Randomized scoreboard bench for scr1_dmem_arb; a round-robin and a fixed-priority
// instance share the same stimulus and a simple memory model.
module tb_scr1_dmem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          p0_req, p0_cmd, p1_req, p1_cmd, mem_ack;
  logic [1:0]    p0_width, p1_width, mem_resp;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, mem_rdata;

  logic          r_ack0, r_ack1, r_req, r_cmd, r_unexp;
  logic [1:0]    r_resp0, r_resp1, r_width;
  logic [DW-1:0] r_rdata0, r_rdata1, r_wdata;
  logic [AW-1:0] r_addr;
  logic          f_ack0, f_ack1, f_req, f_cmd, f_unexp;
  logic [1:0]    f_resp0, f_resp1, f_width;
  logic [DW-1:0] f_rdata0, f_rdata1, f_wdata;
  logic [AW-1:0] f_addr;

  scr1_dmem_arb #(.DMEM_AWIDTH(AW), .DMEM_DWIDTH(DW), .ARB_RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_cmd_i(p0_cmd), .p0_width_i(p0_width), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_req_ack_o(r_ack0), .p0_rdata_o(r_rdata0), .p0_resp_o(r_resp0),
    .p1_req_i(p1_req), .p1_cmd_i(p1_cmd), .p1_width_i(p1_width), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_req_ack_o(r_ack1), .p1_rdata_o(r_rdata1), .p1_resp_o(r_resp1),
    .dmem_req_o(r_req), .dmem_cmd_o(r_cmd), .dmem_width_o(r_width), .dmem_addr_o(r_addr),
    .dmem_wdata_o(r_wdata), .dmem_req_ack_i(mem_ack), .dmem_rdata_i(mem_rdata),
    .dmem_resp_i(mem_resp), .arb_unexp_resp_o(r_unexp)
  );

  scr1_dmem_arb #(.DMEM_AWIDTH(AW), .DMEM_DWIDTH(DW), .ARB_RR(1'b0)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_cmd_i(p0_cmd), .p0_width_i(p0_width), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_req_ack_o(f_ack0), .p0_rdata_o(f_rdata0), .p0_resp_o(f_resp0),
    .p1_req_i(p1_req), .p1_cmd_i(p1_cmd), .p1_width_i(p1_width), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_req_ack_o(f_ack1), .p1_rdata_o(f_rdata1), .p1_resp_o(f_resp1),
    .dmem_req_o(f_req), .dmem_cmd_o(f_cmd), .dmem_width_o(f_width), .dmem_addr_o(f_addr),
    .dmem_wdata_o(f_wdata), .dmem_req_ack_i(mem_ack), .dmem_rdata_i(mem_rdata),
    .dmem_resp_i(mem_resp), .arb_unexp_resp_o(f_unexp)
  );

  typedef struct packed {
    logic        port;
    logic [1:0]  code;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: whether a transaction is in flight, its scripted response,
  // and the round-robin preference (instance 0 only).
  bit          outstanding = 1'b0;
  int          countdown   = 0;
  logic [1:0]  pend_code   = 2'd0;
  logic [31:0] pend_rdata  = '0;
  int          rr_pref     = 0;
  logic [1:0]  next_code   = 2'd1;
  logic [31:0] next_rdata  = '0;
  int          next_cd     = 0;

  function automatic int grant_of(int d);
    if (!rst_n) return 0;
    if (p0_req && p1_req) return (d == 0) ? rr_pref : 0;
    return p1_req ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic req, input logic cmd, input logic [1:0] width,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic ack0,
                           input logic ack1, input logic unexp, input logic [31:0] rd0,
                           input logic [31:0] rd1);
    int g;
    bit ereq;
    g    = grant_of(d);
    ereq = rst_n && !outstanding && (p0_req || p1_req);
    chk($sformatf("dmem_req[%0d]", d), req, ereq);
    chk($sformatf("ack0[%0d]", d), ack0, ereq && mem_ack && g == 0);
    chk($sformatf("ack1[%0d]", d), ack1, ereq && mem_ack && g == 1);
    chk($sformatf("unexp[%0d]", d), unexp,
        rst_n && !outstanding && (mem_resp == 2'd1 || mem_resp == 2'd2));
    chk($sformatf("rdata_bcast[%0d]", d), {rd0 ^ rd1}, '0);
    chk($sformatf("rdata0[%0d]", d), rd0, mem_rdata);
    if (!outstanding) begin
      chk($sformatf("addr[%0d]", d), addr, (g == 1) ? p1_addr : p0_addr);
      chk($sformatf("wdata[%0d]", d), wdata, (g == 1) ? p1_wdata : p0_wdata);
      chk($sformatf("cmd_width[%0d]", d), {cmd, width},
          (g == 1) ? {p1_cmd, p1_width} : {p0_cmd, p0_width});
    end
  endtask

  task automatic model_update();
    int g;
    exp_t e;
    if (!rst_n) begin
      outstanding = 1'b0;
      rr_pref     = 0;
    end else if (!outstanding) begin
      if ((p0_req || p1_req) && mem_ack) begin
        pend_code  = next_code;
        pend_rdata = next_rdata;
        countdown  = next_cd;
        for (int d = 0; d < 2; d++) begin
          g       = grant_of(d);
          e.port  = (g == 1);
          e.code  = pend_code;
          e.rdata = pend_rdata;
          if (d == 0) begin
            sbq0.push_back(e);
            rr_pref = 1 - g;
          end else begin
            sbq1.push_back(e);
          end
        end
        outstanding = 1'b1;
      end
    end else if (mem_resp == 2'd1 || mem_resp == 2'd2) begin
      outstanding = 1'b0;
    end else if (countdown > 0) begin
      countdown--;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(negedge clk);
    check_dut(0, r_req, r_cmd, r_width, r_addr, r_wdata, r_ack0, r_ack1, r_unexp, r_rdata0, r_rdata1);
    check_dut(1, f_req, f_cmd, f_width, f_addr, f_wdata, f_ack0, f_ack1, f_unexp, f_rdata0, f_rdata1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic mem_drive(input bit allow_stray);
    if (outstanding && countdown == 0) begin
      mem_resp  = pend_code;
      mem_rdata = pend_rdata;
    end else begin
      mem_resp  = (allow_stray && !outstanding && $urandom_range(0, 15) == 0) ? 2'd1 : 2'd0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic rand_fields();
    p0_cmd   = 1'($urandom_range(0, 1));
    p1_cmd   = 1'($urandom_range(0, 1));
    p0_width = 2'($urandom_range(0, 2));
    p1_width = 2'($urandom_range(0, 2));
    p0_addr  = $urandom;
    p1_addr  = $urandom;
    p0_wdata = $urandom;
    p1_wdata = $urandom;
  endtask

  task automatic mon(input int d, input logic [1:0] r0, input logic [1:0] r1,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    exp_t e;
    logic port;
    logic [1:0] code;
    logic [31:0] rd;
    if (r0 != 2'd0 || r1 != 2'd0) begin
      tests++;
      port = (r1 != 2'd0);
      code = port ? r1 : r0;
      rd   = port ? rd1 : rd0;
      if (r0 != 2'd0 && r1 != 2'd0) begin
        fails++;
        $display("FAIL resp_onehot[%0d]: got p0=%0d p1=%0d expected at most one", d, r0, r1);
      end else if ((d == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0)) begin
        fails++;
        $display("FAIL resp_unexpected[%0d]: got port%0d code %0d expected none", d, port, code);
      end else begin
        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        if ({port, code, rd} !== {e.port, e.code, e.rdata}) begin
          fails++;
          $display("FAIL resp[%0d]: got port%0d code %0d rdata %h expected port%0d code %0d rdata %h",
                   d, port, code, rd, e.port, e.code, e.rdata);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, r_resp0, r_resp1, r_rdata0, r_rdata1);
    mon(1, f_resp0, f_resp1, f_rdata0, f_rdata1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; mem_ack = 1'b1; mem_resp = 2'd1; mem_rdata = '0;
    rand_fields();
    @(posedge clk); #1;
    step();                                  // outputs quiet and port 0 muxed while in reset
    rst_n = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; mem_ack = 1'b0; mem_resp = 2'd0;
    step();

    // Port 0 read of 0x100, response two cycles after accept.
    p0_req = 1'b1; p0_cmd = 1'b0; p0_width = 2'd2; p0_addr = 32'h100;
    mem_ack = 1'b1; next_code = 2'd1; next_rdata = 32'hDEADBEEF; next_cd = 1;
    mem_drive(1'b0); step();
    for (int i = 0; i < 3; i++) begin
      mem_drive(1'b0); step();
    end
    p0_req = 1'b0; mem_ack = 1'b0; mem_drive(1'b0); step();

    // Both ports hold requests; memory acks every idle cycle, responds next cycle.
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h10; p1_addr = 32'h20; mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_code = 2'd1; next_rdata = $urandom; next_cd = 0;
      mem_drive(1'b0); step();
    end
    while (outstanding) begin
      p0_req = 1'b0; p1_req = 1'b0; mem_ack = 1'b0; mem_drive(1'b0); step();
    end

    // Ack withheld three cycles, then port 0 withdraws; port 1 error write.
    p0_req = 1'b1; p1_req = 1'b1; p1_cmd = 1'b1; mem_ack = 1'b0; mem_resp = 2'd0;
    for (int i = 0; i < 3; i++) step();
    p0_req = 1'b0; mem_ack = 1'b1; next_code = 2'd2; next_rdata = $urandom; next_cd = 0;
    step();
    p1_req = 1'b0; mem_ack = 1'b0; mem_drive(1'b0); step();
    mem_drive(1'b0); step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      p0_req = ($urandom_range(0, 2) != 0);
      p1_req = ($urandom_range(0, 2) != 0);
      rand_fields();
      mem_ack    = 1'($urandom_range(0, 1)) & (p0_req | p1_req);
      next_code  = 2'($urandom_range(1, 2));
      next_rdata = $urandom;
      next_cd    = $urandom_range(0, 3);
      mem_drive(1'b1);
      step();
    end

    // Reset while busy drops the in-flight response.
    p0_req = 1'b1; p1_req = 1'b0; mem_ack = 1'b1; next_cd = 3;
    for (int i = 0; i < 20 && !outstanding; i++) begin
      mem_drive(1'b0); step();
    end
    chk("busy_before_reset", outstanding, 1'b1);
    rst_n = 1'b0; outstanding = 1'b0; rr_pref = 0;
    sbq0.delete(); sbq1.delete();
    p1_req = 1'b1; mem_resp = 2'd1; mem_rdata = $urandom;
    step();
    rst_n = 1'b1; p0_req = 1'b0; p1_req = 1'b0; mem_ack = 1'b0;
    mem_resp = 2'd1; mem_rdata = $urandom;   // stray response while idle
    step();
    mem_resp = 2'd0; p0_req = 1'b1; p1_req = 1'b1; rand_fields();
    step();                                  // pointer back at port 0

    // Drain.
    p0_req = 1'b0; p1_req = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 10 && outstanding; i++) begin
      mem_drive(1'b0); step();
    end
    chk("drain_idle", outstanding, 1'b0);
    mem_resp = 2'd0; step();
    chk("sb0_empty", sbq0.size(), 0);
    chk("sb1_empty", sbq1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scr1_dmem_arb.md
Name: scr1_dmem_arb

Overview:
- Two-requester arbiter for the core data-memory port.
- Port 0 is the LSU; port 1 is a secondary master (debug system-bus access or DMA).
- Allows one outstanding transaction at a time, remembers the granted port, and routes the response back only to that port.
- Sits between the pipeline LSU and the DMEM router, using the standard SCR1 memory handshake (req/req_ack, then resp).

Parameters:
- DMEM_AWIDTH, 32, address width.
- DMEM_DWIDTH, 32, data width.
- ARB_RR, 1, arbitration mode: 1 = round-robin between ports; 0 = fixed priority with port 0 highest.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- p0_req_i  in  1  port 0 request.
- p0_cmd_i  in  1  port 0 command (0=RD, 1=WR).
- p0_width_i  in  2  port 0 width (0=BYTE, 1=HWORD, 2=WORD).
- p0_addr_i  in  DMEM_AWIDTH  port 0 address.
- p0_wdata_i  in  DMEM_DWIDTH  port 0 write data.
- p0_req_ack_o  out  1  port 0 request accepted.
- p0_rdata_o  out  DMEM_DWIDTH  port 0 read data.
- p0_resp_o  out  2  port 0 response (0=NOTRDY, 1=RDY_OK, 2=RDY_ER).
- p1_req_i, p1_cmd_i, p1_width_i, p1_addr_i, p1_wdata_i  in  (same widths as port 0)  port 1 request fields.
- p1_req_ack_o, p1_rdata_o, p1_resp_o  out  (same widths as port 0)  port 1 ack, read data, response.
- dmem_req_o  out  1  memory request.
- dmem_cmd_o  out  1  memory command.
- dmem_width_o  out  2  memory width.
- dmem_addr_o  out  DMEM_AWIDTH  memory address.
- dmem_wdata_o  out  DMEM_DWIDTH  memory write data.
- dmem_req_ack_i  in  1  memory accepted request.
- dmem_rdata_i  in  DMEM_DWIDTH  memory read data.
- dmem_resp_i  in  2  memory response.
- arb_unexp_resp_o  out  1  one-cycle pulse: response seen while IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE → BUSY when dmem_req_o & dmem_req_ack_i.
  - BUSY → IDLE when dmem_resp_i is RDY_OK or RDY_ER.
  - BUSY holds on NOTRDY. A value of 3 is treated as NOTRDY.
- Registers, with reset values:
  - state = IDLE.
  - owner_ff = 0 (port that owns the outstanding transaction).
  - rr_ptr_ff = 0 (preferred port when both request).
- Grant (combinational, IDLE only):
  - Only one port requesting → that port.
  - Both requesting → ARB_RR=1 selects rr_ptr_ff; ARB_RR=0 selects port 0.
  - Grant is re-evaluated every IDLE cycle. A requester may drop req before ack without penalty; no lock is taken before ack.
- Request path:
  - dmem_req_o = (state==IDLE) & (p0_req_i | p1_req_i).
  - cmd/width/addr/wdata are muxed from the granted port; port 0 fields are driven when neither port requests.
  - In BUSY, dmem_req_o = 0, regardless of requests.
- Acks:
  - px_req_ack_o = dmem_req_ack_i & (state==IDLE) & (grant==x).
  - The non-granted port's ack is always 0.
- On accept:
  - owner_ff ← grant.
  - rr_ptr_ff ← ~grant. This applies only when ARB_RR=1; otherwise rr_ptr_ff holds.
- Response path:
  - dmem_rdata_i is broadcast to both rdata outputs.
  - In BUSY, p[owner]_resp_o = dmem_resp_i.
  - The other port's resp is always NOTRDY.
  - In IDLE, both resp outputs are NOTRDY.
- Latency:
  - Zero added cycles on the request and response paths.
  - A new request is issued no earlier than the cycle after the response cycle (single outstanding transaction).
- Unexpected response: dmem_resp_i ≠ NOTRDY while IDLE:
  - Not forwarded to either port.
  - arb_unexp_resp_o = 1 that cycle; it is combinational.
  - State unchanged.
- Output values in reset:
  - dmem_req_o = 0.
  - Both acks = 0.
  - Both resp = NOTRDY.
  - arb_unexp_resp_o = 0.
  - Mux outputs follow port 0 inputs.
- Reset mid-transaction: state returns to IDLE and the outstanding response is dropped. The memory side is reset from the same rst_n.
- Simultaneous response and new request (BUSY, resp OK): the request is not issued that cycle; it is issued next cycle from IDLE.
- A port holding req while the other is BUSY-owner sees ack=0 and resp=NOTRDY until the arbiter returns to IDLE.
- Assertions (simulation):
  - Acks are onehot0.
  - No dmem_req_o in BUSY.
  - Responses are onehot0 across ports.
  - No X on dmem controls when dmem_req_o=1.

Test Plan:
- Port 0 only, RD addr 0x100, ack same cycle, resp RDY_OK with rdata 0xDEADBEEF two cycles later → p0_resp_o=RDY_OK, p0_rdata_o=0xDEADBEEF; p1_resp_o stays NOTRDY; dmem_req_o low during BUSY.
- ARB_RR=1, both ports hold req continuously, memory acks every IDLE cycle and responds one cycle later → grants alternate 0,1,0,1; addr toggles between p0_addr (0x10) and p1_addr (0x20).
- ARB_RR=0, same stimulus → port 0 granted every transaction; port 1 ack stays 0 while port 0 requests.
- Port 1 WR, memory returns RDY_ER → p1_resp_o=RDY_ER for one cycle, p0_resp_o=NOTRDY; FSM back to IDLE.
- Memory withholds ack for 3 cycles while both ports request, then port 0 drops req → grant moves to port 1; port 1 is acked and owns the response.
- rst_n asserted while BUSY, then released; a stray RDY_OK arrives in IDLE → neither port sees it, arb_unexp_resp_o pulses 1 for one cycle, rr_ptr_ff=0.
